// File: rtl/fetch_requester.sv
// Instruction-fetch requester: owns the fetch PC, issues credit-limited word fetches,
// buffers in-order responses for decode and discards stale responses after redirects.
module fetch_requester #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_instr_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned SW = CW + 2;

  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(1'b0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);
  localparam logic [SW-1:0] DEPTH_S  = SW'(BUF_DEPTH);

  function automatic logic [31:0] pc_step(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [PW-1:0] ptr_step(input logic [PW-1:0] ptr);
    return (ptr == PTR_LAST) ? PTR_ZERO : ptr + PTR_ONE;
  endfunction

  logic [31:0]   fetch_pc_r;
  logic [31:0]   rsp_pc_r;
  logic [CW-1:0] outst_r;
  logic [CW-1:0] drop_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [31:0]   buf_pc_r    [BUF_DEPTH];
  logic [31:0]   buf_instr_r [BUF_DEPTH];

  logic          pop_s;
  logic          req_valid_s;
  logic          accept_s;
  logic          rsp_keep_s;
  logic          rsp_drop_s;
  logic [SW-1:0] credit_sum_s;
  logic [31:0]   redir_target_s;
  logic [CW-1:0] redir_drop_s;
  logic          unused_s;

  // Handshake decode, request credit and redirect bookkeeping.
  always_comb begin
    pop_s          = (count_r != CNT_ZERO) & instr_ready_i;
    // Everything that could still land in the buffer, less the slot freed this cycle.
    credit_sum_s   = {2'b00, outst_r} + {2'b00, drop_r} + {2'b00, count_r}
                   - {{(SW-1){1'b0}}, pop_s};
    req_valid_s    = ~rst_i & ~redirect_valid_i & (credit_sum_s < DEPTH_S);
    accept_s       = req_valid_s & imem_req_ready_i;
    rsp_keep_s     = imem_rsp_valid_i & (drop_r == CNT_ZERO);
    rsp_drop_s     = imem_rsp_valid_i & (drop_r != CNT_ZERO);
    redir_target_s = {redirect_pc_i[31:2], 2'b00};
    // Every in-flight response is stale after a redirect, minus the one arriving now.
    redir_drop_s   = drop_r + outst_r - {{(CW-1){1'b0}}, imem_rsp_valid_i};
    unused_s       = ^redirect_pc_i[1:0];
  end

  assign imem_req_valid_o = req_valid_s;
  assign imem_req_addr_o  = fetch_pc_r;
  assign instr_valid_o    = (count_r != CNT_ZERO);
  assign instr_o          = buf_instr_r[rd_ptr_r];
  assign pc_o             = buf_pc_r[rd_ptr_r];

  // Fetch PC, response PC, in-flight counters and the instruction buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
      outst_r    <= CNT_ZERO;
      drop_r     <= CNT_ZERO;
      count_r    <= CNT_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        buf_pc_r[i]    <= 32'h0000_0000;
        buf_instr_r[i] <= 32'h0000_0000;
      end
    end else if (redirect_valid_i) begin
      fetch_pc_r <= redir_target_s;
      rsp_pc_r   <= redir_target_s;
      outst_r    <= CNT_ZERO;
      drop_r     <= redir_drop_s;
      count_r    <= CNT_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
    end else begin
      if (accept_s) begin
        fetch_pc_r <= pc_step(fetch_pc_r);
      end

      case ({accept_s, rsp_keep_s})
        2'b10:   outst_r <= outst_r + CNT_ONE;
        2'b01:   outst_r <= outst_r - CNT_ONE;
        default: outst_r <= outst_r;
      endcase

      if (rsp_drop_s) begin
        drop_r <= drop_r - CNT_ONE;
      end

      if (rsp_keep_s) begin
        buf_pc_r[wr_ptr_r]    <= rsp_pc_r;
        buf_instr_r[wr_ptr_r] <= imem_rsp_instr_i;
        wr_ptr_r              <= ptr_step(wr_ptr_r);
        rsp_pc_r              <= pc_step(rsp_pc_r);
      end

      if (pop_s) begin
        rd_ptr_r <= ptr_step(rd_ptr_r);
      end

      case ({rsp_keep_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_requester.sv
// Randomized bench for fetch_requester: a latency-configurable memory model feeds the DUT
// and a scoreboard of expected {pc, instr} pairs is checked against what decode receives.
module tb_fetch_requester;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_instr_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  always #5 clk_i = ~clk_i;

  fetch_requester #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_instr_i (imem_rsp_instr_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .pc_o             (pc_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        pend_q[$];   // accepted by memory, not yet answered
  ent_t        exp_q[$];    // what decode should see, in order
  req_t        cur_rsp;
  int          vectors = 0;
  int          miscompares = 0;
  int          edge_n = 0;
  int          epoch = 0;
  int          lat = 1;
  int          ready_pct = 100;
  int          rsp_pct = 100;
  int          pops = 0;
  logic [31:0] next_addr = RST_PC;
  logic        rst_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_i) edge_n <= edge_n + 1;

  // Memory: in-order responses, at least one cycle after acceptance, with random gaps.
  always @(negedge clk_i) begin
    imem_rsp_valid_i = 1'b0;
    imem_rsp_instr_i = 32'h0000_0000;
    if (pend_q.size() > 0 && edge_n + 1 >= pend_q[0].due &&
        $urandom_range(99) < rsp_pct) begin
      cur_rsp          = pend_q.pop_front();
      imem_rsp_valid_i = 1'b1;
      imem_rsp_instr_i = cur_rsp.addr | 32'h0000_0001;
    end
    imem_req_ready_i = ($urandom_range(99) < ready_pct);
  end

  // Monitor: compares DUT outputs with the model, then advances the model by one edge.
  always @(negedge clk_i) begin
    int inflight;
    bit pop_exp;
    bit exp_rv;
    bit acc;
    #2;
    inflight = pend_q.size() + (imem_rsp_valid_i ? 1 : 0);
    pop_exp  = (exp_q.size() > 0) && instr_ready_i;
    exp_rv   = !rst_i && !redirect_valid_i &&
               (inflight + exp_q.size() - (pop_exp ? 1 : 0) < DEPTH);

    if (rst_prev) begin
      check("reset_instr", instr_o, 32'h0000_0000);
      check("reset_pc", pc_o, 32'h0000_0000);
    end
    check("req_valid", {31'd0, imem_req_valid_o}, {31'd0, exp_rv});
    check("instr_valid", {31'd0, instr_valid_o}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() > 0 && instr_valid_o) begin
      check("head_pc", pc_o, exp_q[0].pc);
      check("head_instr", instr_o, exp_q[0].instr);
    end
    acc = imem_req_valid_o && imem_req_ready_i;

    if (rst_i) begin
      pend_q.delete();
      exp_q.delete();
      next_addr = RST_PC;
      epoch++;
    end else if (redirect_valid_i) begin
      exp_q.delete();
      next_addr = {redirect_pc_i[31:2], 2'b00};
      epoch++;
    end else begin
      if (pop_exp) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (imem_rsp_valid_i && cur_rsp.epoch == epoch)
        exp_q.push_back('{pc: cur_rsp.addr, instr: cur_rsp.addr | 32'h0000_0001});
      if (acc) begin
        check("req_addr", imem_req_addr_o, next_addr);
        pend_q.push_back('{addr: next_addr, epoch: epoch, due: edge_n + 1 + lat});
        next_addr = next_addr + 32'd4;
      end
    end
    rst_prev = rst_i;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = target;
    step(1);
    redirect_valid_i = 1'b0;
  endtask

  initial begin
    int start;
    rst_i            = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0000_0000;
    instr_ready_i    = 1'b1;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_instr_i = 32'h0000_0000;
    step(3);
    rst_i = 1'b0;

    // Streaming with a 1-cycle memory: one instruction per cycle after the pipeline fills.
    start = pops;
    step(30);
    check("throughput", {31'd0, (pops - start) >= 27}, 32'd1);

    // Decode stalled, then released.
    instr_ready_i = 1'b0;
    step(10);
    check("bp_stall_valid", {31'd0, imem_req_valid_o}, 32'd0);
    instr_ready_i = 1'b1;
    step(10);

    // Redirect with responses in flight on a 3-cycle memory.
    lat = 3;
    step(6);
    redirect_to(32'h0000_0103);
    check("redir_addr", imem_req_addr_o, 32'h0000_0100);
    step(12);

    // Redirect in the same cycle a response arrives.
    lat = 2;
    for (int i = 0; i < 20 && !imem_rsp_valid_i; i++) step(1);
    check("coincide_wait", {31'd0, imem_rsp_valid_i}, 32'd1);
    redirect_to(32'h0000_0200);
    step(10);

    // Address wrap.
    lat = 1;
    redirect_to(32'hFFFF_FFF8);
    step(10);

    // Randomized traffic with redirects, including back-to-back ones.
    ready_pct = 70;
    rsp_pct   = 70;
    for (int i = 0; i < 1500; i++) begin
      lat              = $urandom_range(3, 1);
      instr_ready_i    = ($urandom_range(99) < 70);
      redirect_valid_i = ($urandom_range(99) < 5);
      redirect_pc_i    = $urandom_range(1) ? $urandom : (32'hFFFF_FFF0 | $urandom_range(15));
      step(1);
    end
    redirect_valid_i = 1'b0;

    // Reset with a full buffer and responses outstanding.
    ready_pct     = 100;
    rsp_pct       = 100;
    lat           = 3;
    instr_ready_i = 1'b0;
    step(8);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    check("post_reset_valid", {31'd0, instr_valid_o}, 32'd0);
    check("post_reset_addr", imem_req_addr_o, RST_PC);
    instr_ready_i = 1'b1;
    lat = 1;
    step(15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_requester.md
# fetch_requester

Requester side of the instruction-memory interface. It owns the fetch PC, issues word-aligned fetch requests to the instruction memory, and receives in-order responses. Responses go into a small instruction buffer that decode drains over a valid/ready handshake. It also handles control-flow redirects, discarding every response still in flight from the old path.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- BUF_DEPTH, 4: instruction buffer entries; must be at least 2. This is also the cap on outstanding plus buffered fetches.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts the request this cycle.
- imem_req_addr_o  out  32  fetch address; bits [1:0] always 0.
- imem_rsp_valid_i  in  1  response valid. Responses cannot be backpressured.
- imem_rsp_instr_i  in  32  instruction word.
- redirect_valid_i  in  1  redirect fetch to a new PC.
- redirect_pc_i  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- instr_valid_o  out  1  buffer head valid.
- instr_ready_i  in  1  decode consumes the head.
- instr_o  out  32  head instruction.
- pc_o  out  32  PC of the head instruction.

## Operation
- **State:**
  - fetch_pc, 32 bits.
  - rsp_pc, 32 bits: PC of the next kept response.
  - outstanding counter, 0..BUF_DEPTH: requests accepted and not yet responded.
  - drop counter, 0..BUF_DEPTH: responses still to discard.
  - circular buffer of {pc, instr} with read pointer, write pointer and count.
- **Accept and pop:**
  - accept = imem_req_valid_o & imem_req_ready_i.
  - pop = instr_valid_o & instr_ready_i.
- **Request credit:**
  - imem_req_valid_o = ~rst_i & ~redirect_valid_i & (outstanding + drop + count − pop < BUF_DEPTH).
  - This guarantees every response has a free buffer slot.
  - imem_req_addr_o = fetch_pc.
  - The request may be withdrawn or changed only after acceptance, or on redirect.
- **On accept:**
  - fetch_pc += 4, 32-bit wrap: 32'hFFFF_FFFC → 32'h0000_0000.
  - outstanding += 1.
- **On response, when drop > 0:**
  - drop −= 1.
  - The response is discarded; the buffer is untouched.
- **On response, when drop == 0:**
  - Write {rsp_pc, imem_rsp_instr_i} at the write pointer.
  - rsp_pc += 4, same wrap rule.
  - outstanding −= 1.
- **On pop:** the read pointer advances and count −= 1.
- **Simultaneous write and pop:** count is unchanged.
- **Redirect (redirect_valid_i high), with target T = {redirect_pc_i[31:2], 2'b00}:**
  - Takes priority over everything else that cycle.
  - fetch_pc ← T and rsp_pc ← T.
  - The buffer is flushed: count = 0, pointers reset.
  - drop ← drop + outstanding − (1 if a response arrived this cycle and was counted in outstanding, else 0).
  - outstanding ← 0.
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle is ignored internally; decode must treat its own flush as authoritative.
- **Back-to-back redirects:** each applies its own target. Drop accumulates correctly because credit bounds outstanding + drop to BUF_DEPTH.
- **Outputs:** instr_valid_o = (count != 0). instr_o and pc_o come from the head entry.
- **Memory contract:** responses are in order, one per accepted request, and arrive at least 1 cycle after acceptance.

## Timing
- **Reset** (rst_i high at a rising edge):
  - fetch_pc = rsp_pc = RESET_PC.
  - All counters and pointers 0, buffer contents 0.
  - Applies in any state, mid-flight included. Responses to pre-reset requests are the memory's responsibility to cancel.
- **Output values during and after reset:**
  - imem_req_valid_o = 0 while rst_i is high.
  - instr_valid_o = 0, instr_o = 0, pc_o = 0.
- **First request:** imem_req_valid_o is 1 with addr RESET_PC in the first cycle after rst_i falls.
- **Latency:**
  - Response in cycle N gives instr_valid_o in cycle N+1.
  - Redirect in cycle N gives a request to T in cycle N+1. instr_valid_o is 0 in N+1.
- **Throughput:** 1 instruction/cycle sustained with a 1-cycle memory, always-ready memory and always-ready decode.
- **Full buffer:** with decode stalled, requests stop once outstanding + count = BUF_DEPTH. Without a redirect, the buffer never overflows.
- **Empty buffer:** instr_valid_o = 0; instr_ready_i is ignored.

## Test plan
- **Reset fetch:**
  - Stimulus: reset, then a 1-cycle memory returning addr|1, decode always ready.
  - Required: requests at 0x0, 0x4, 0x8…, one per cycle. instr_o/pc_o pairs (0x1,0x0), (0x5,0x4)… appear 2 cycles after each request.
- **Backpressure:**
  - Stimulus: instr_ready_i held 0 for 10 cycles.
  - Required: exactly 4 requests issued, then imem_req_valid_o = 0. After release, 4 pops in order with pcs 0x0–0xC, then fetch resumes at 0x10.
- **Redirect with in-flight responses:**
  - Stimulus: 3-cycle memory latency; redirect to 0x103 while 2 requests are outstanding.
  - Required: both stale responses are dropped. The next request is to 0x100, and the first delivered pc_o is 0x100.
- **Redirect coincident with a response:**
  - Stimulus: redirect in the same cycle as a response.
  - Required: that response is discarded, the drop count excludes it, and no spurious instruction is delivered.
- **PC wrap:**
  - Stimulus: redirect to 0xFFFF_FFF8.
  - Required: requests to 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, with matching pc_o values.
- **Mid-flight reset:**
  - Stimulus: assert rst_i with a full buffer and 2 responses outstanding.
  - Required: the next cycle shows instr_valid_o = 0 and a request to RESET_PC one cycle after release.
